// File: rtl/mac_norm_stg_pkg.sv
// Shared definitions for the MAC normalisation stage: default widths,
// exponent-adjust width and the flag bit positions read by the output packer.
package mac_norm_stg_pkg;

    localparam int unsigned DEF_PSUM_W = 19;
    localparam int unsigned DEF_EXP_W  = 6;
    localparam int unsigned DEF_FRAC_W = 11;
    localparam int unsigned DEF_QF_W   = 5;

    // Signed shift/exponent adjust carries two bits beyond the exponent.
    localparam int unsigned DEF_ADJ_W  = DEF_EXP_W + 2;

    // Flag vector layout shared with the downstream packer.
    localparam int unsigned FLG_W     = 3;
    localparam int unsigned FLG_ZERO  = 0;
    localparam int unsigned FLG_OFLOW = 1;
    localparam int unsigned FLG_UFLOW = 2;

    function automatic int unsigned adj_width(input int unsigned exp_w);
        return exp_w + 2;
    endfunction

endpackage

// File: rtl/mac_norm_stg_lzd.sv
// mac_lzd: combinational leading-one detector; o_pos is the index of the
// highest set bit of i_val, o_nz flags a nonzero input.
module mac_lzd import mac_norm_stg_pkg::*; #(
    parameter int unsigned W   = DEF_PSUM_W,
    parameter int unsigned P_W = $clog2(W)
) (
    input  logic [W-1:0]   i_val,
    output logic [P_W-1:0] o_pos,
    output logic           o_nz
);

    // Scan upward so the last hit is the most significant set bit.
    always_comb begin
        o_pos = '0;
        o_nz  = 1'b0;
        for (int unsigned i = 0; i < W; i++) begin
            if (i_val[i]) begin
                o_pos = P_W'(i);
                o_nz  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mac_norm_stg.sv
// mac_norm_stg: normalises a two's-complement partial sum to a sign /
// mantissa-with-explicit-one / biased-exponent triple, one cycle latency,
// valid/ready handshake with an output entry plus a one-deep skid entry.
// Optional build macro MAC_NORM_RNE_EN: round-to-nearest-even on dropped
// mantissa bits instead of truncation.
module mac_norm_stg import mac_norm_stg_pkg::*; #(
    parameter int unsigned PSUM_W = DEF_PSUM_W,
    parameter int unsigned EXP_W  = DEF_EXP_W,
    parameter int unsigned FRAC_W = DEF_FRAC_W,
    parameter int unsigned QF_W   = DEF_QF_W
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_flush,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [PSUM_W-1:0] i_psum,
    input  logic [EXP_W-1:0]  i_max_exp,
    input  logic [QF_W-1:0]   i_Q_frac,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_sgn,
    output logic [FRAC_W-1:0] o_norm_sum,
    output logic [EXP_W-1:0]  o_exp,
    output logic              o_zero,
    output logic              o_oflow,
    output logic              o_uflow,
    output logic [QF_W-1:0]   o_Q_frac
);

    localparam int unsigned P_W  = $clog2(PSUM_W);
    localparam int unsigned A_W  = adj_width(EXP_W);
    localparam int unsigned E_W  = A_W + 1;
    localparam int unsigned BW   = QF_W + FLG_W + EXP_W + FRAC_W + 1;
    localparam logic signed [E_W-1:0] E_MAX = E_W'((1 << EXP_W) - 1);
    localparam logic signed [E_W-1:0] E_MIN = E_W'(1);

    logic                    sgn_in;
    logic [PSUM_W-1:0]       mag;
    logic [P_W-1:0]          lead;
    logic                    nz;
    logic signed [A_W-1:0]   adj;
    logic [A_W-1:0]          adj_mag;
    logic [PSUM_W-1:0]       shr;
    logic [PSUM_W-1:0]       shl;
    logic [FRAC_W-1:0]       mant_t;
    logic [FRAC_W-1:0]       mant;
    logic                    rnd_carry;
    logic signed [E_W-1:0]   e;

    logic                    sgn_n;
    logic [FRAC_W-1:0]       norm_n;
    logic [EXP_W-1:0]        exp_n;
    logic [FLG_W-1:0]        flg_n;
    logic [BW-1:0]           beat_in;

    logic [BW-1:0]           out_q;
    logic [BW-1:0]           skid_q;
    logic                    out_v;
    logic                    skid_v;
    logic [FLG_W-1:0]        flg_o;
    logic                    in_xfer;
    logic                    out_xfer;

    mac_lzd #(
        .W   (PSUM_W),
        .P_W (P_W)
    ) u_lzd (
        .i_val (mag),
        .o_pos (lead),
        .o_nz  (nz)
    );

    // Magnitude, alignment shift and exponent adjust for the incoming beat.
    always_comb begin
        sgn_in  = i_psum[PSUM_W-1];
        mag     = sgn_in ? (~i_psum + PSUM_W'(1)) : i_psum;
        adj     = $signed(A_W'(lead)) - $signed(A_W'(FRAC_W - 1));
        adj_mag = adj[A_W-1] ? unsigned'(-adj) : unsigned'(adj);
        shr     = mag >> adj_mag;
        shl     = mag << adj_mag;
        mant_t  = adj[A_W-1] ? shl[FRAC_W-1:0] : shr[FRAC_W-1:0];
    end

`ifdef MAC_NORM_RNE_EN
    logic [PSUM_W-1:0] half;
    logic [PSUM_W-1:0] dropped;
    logic              guard;
    logic              sticky;
    logic              rnd_up;
    logic [FRAC_W:0]   mant_sum;

    // Round to nearest, ties to even; a carry out of the mantissa becomes
    // 1.000.. with the exponent bumped, before the overflow test.
    always_comb begin
        half      = PSUM_W'(1) << (adj_mag - 1'b1);
        dropped   = mag & ((PSUM_W'(1) << adj_mag) - PSUM_W'(1));
        guard     = |(dropped & half);
        sticky    = |(dropped & (half - PSUM_W'(1)));
        rnd_up    = !adj[A_W-1] && guard && (sticky || mant_t[0]);
        mant_sum  = {1'b0, mant_t} + (FRAC_W + 1)'(rnd_up);
        rnd_carry = mant_sum[FRAC_W];
        mant      = rnd_carry ? {1'b1, {(FRAC_W - 1){1'b0}}} : mant_sum[FRAC_W-1:0];
    end
`else
    assign rnd_carry = 1'b0;
    assign mant      = mant_t;
`endif

    // Final exponent, range checks and special-case selection.
    always_comb begin
        e      = $signed(E_W'(i_max_exp)) + $signed({adj[A_W-1], adj})
               + $signed(E_W'(rnd_carry));
        sgn_n  = 1'b0;
        norm_n = '0;
        exp_n  = '0;
        flg_n  = '0;
        if (!nz) begin
            flg_n[FLG_ZERO] = 1'b1;
        end else if (e > E_MAX) begin
            sgn_n            = sgn_in;
            norm_n           = '1;
            exp_n            = '1;
            flg_n[FLG_OFLOW] = 1'b1;
        end else if (e < E_MIN) begin
            sgn_n            = sgn_in;
            flg_n[FLG_UFLOW] = 1'b1;
        end else begin
            sgn_n  = sgn_in;
            norm_n = mant;
            exp_n  = e[EXP_W-1:0];
        end
        beat_in = {i_Q_frac, flg_n, exp_n, norm_n, sgn_n};
    end

    assign o_ready  = !skid_v;
    assign in_xfer  = i_valid && o_ready;
    assign out_xfer = out_v && i_ready;

    // Output entry plus skid entry; skid only fills while the output is held,
    // and drains into the output entry on the next output transfer.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            out_v  <= 1'b0;
            skid_v <= 1'b0;
            out_q  <= '0;
            skid_q <= '0;
        end else if (i_flush) begin
            out_v  <= 1'b0;
            skid_v <= 1'b0;
        end else if (!out_v || out_xfer) begin
            if (skid_v) begin
                out_q  <= skid_q;
                out_v  <= 1'b1;
                skid_v <= 1'b0;
            end else if (in_xfer) begin
                out_q <= beat_in;
                out_v <= 1'b1;
            end else begin
                out_v <= 1'b0;
            end
        end else if (in_xfer) begin
            skid_q <= beat_in;
            skid_v <= 1'b1;
        end
    end

    assign o_valid = out_v;
    assign {o_Q_frac, flg_o, o_exp, o_norm_sum, o_sgn} = out_q;
    assign o_zero  = flg_o[FLG_ZERO];
    assign o_oflow = flg_o[FLG_OFLOW];
    assign o_uflow = flg_o[FLG_UFLOW];

endmodule

// File: tb/tb_mac_norm_stg.sv
// Directed self-checking bench for mac_norm_stg (default widths).
module tb_mac_norm_stg;

    localparam int unsigned PSUM_W = 19;
    localparam int unsigned EXP_W  = 6;
    localparam int unsigned FRAC_W = 11;
    localparam int unsigned QF_W   = 5;

    logic              i_clk;
    logic              i_rst_n;
    logic              i_flush;
    logic              i_valid;
    logic              o_ready;
    logic [PSUM_W-1:0] i_psum;
    logic [EXP_W-1:0]  i_max_exp;
    logic [QF_W-1:0]   i_Q_frac;
    logic              o_valid;
    logic              i_ready;
    logic              o_sgn;
    logic [FRAC_W-1:0] o_norm_sum;
    logic [EXP_W-1:0]  o_exp;
    logic              o_zero;
    logic              o_oflow;
    logic              o_uflow;
    logic [QF_W-1:0]   o_Q_frac;

    int n_cmp = 0;
    int n_bad = 0;
    int sent;
    int rcv;
    logic stalled;
    logic acc_in;

    mac_norm_stg #(
        .PSUM_W (PSUM_W),
        .EXP_W  (EXP_W),
        .FRAC_W (FRAC_W),
        .QF_W   (QF_W)
    ) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_flush    (i_flush),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_psum     (i_psum),
        .i_max_exp  (i_max_exp),
        .i_Q_frac   (i_Q_frac),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_sgn      (o_sgn),
        .o_norm_sum (o_norm_sum),
        .o_exp      (o_exp),
        .o_zero     (o_zero),
        .o_oflow    (o_oflow),
        .o_uflow    (o_uflow),
        .o_Q_frac   (o_Q_frac)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Presents one beat for one cycle; returns at posedge+1 with i_valid low.
    task automatic send(input logic [PSUM_W-1:0] ps, input logic [EXP_W-1:0] me,
                        input logic [QF_W-1:0] qf);
        i_psum    = ps;
        i_max_exp = me;
        i_Q_frac  = qf;
        i_valid   = 1'b1;
        @(posedge i_clk);
        #1;
        i_valid   = 1'b0;
    endtask

    task automatic expect_beat(input string tag, input logic sgn, input logic [FRAC_W-1:0] norm,
                               input logic [EXP_W-1:0] ex, input logic zero, input logic of,
                               input logic uf, input logic [QF_W-1:0] qf);
        chk({tag, ".valid"}, 32'(o_valid), 32'(1'b1));
        chk({tag, ".sgn"},   32'(o_sgn), 32'(sgn));
        chk({tag, ".norm"},  32'(o_norm_sum), 32'(norm));
        chk({tag, ".exp"},   32'(o_exp), 32'(ex));
        chk({tag, ".zero"},  32'(o_zero), 32'(zero));
        chk({tag, ".oflow"}, 32'(o_oflow), 32'(of));
        chk({tag, ".uflow"}, 32'(o_uflow), 32'(uf));
        chk({tag, ".qf"},    32'(o_Q_frac), 32'(qf));
    endtask

    initial begin
        i_rst_n   = 1'b0;
        i_flush   = 1'b0;
        i_valid   = 1'b0;
        i_ready   = 1'b1;
        i_psum    = '0;
        i_max_exp = '0;
        i_Q_frac  = '0;
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst.valid", 32'(o_valid), 32'd0);
        chk("rst.ready", 32'(o_ready), 32'd1);
        chk("rst.norm",  32'(o_norm_sum), 32'd0);
        chk("rst.exp",   32'(o_exp), 32'd0);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;

        // Single-beat vectors, one-cycle latency.
        send(19'h00400, 6'd20, 5'd1);
        expect_beat("v_pos", 1'b0, 11'h400, 6'd20, 1'b0, 1'b0, 1'b0, 5'd1);
        send(19'h7FFFF, 6'd20, 5'd2);
        expect_beat("v_m1", 1'b1, 11'h400, 6'd10, 1'b0, 1'b0, 1'b0, 5'd2);
        send(19'h40000, 6'd60, 5'd3);
        expect_beat("v_min", 1'b1, 11'h7FF, 6'd63, 1'b0, 1'b1, 1'b0, 5'd3);
        send(19'h00001, 6'd5, 5'd4);
        expect_beat("v_uf", 1'b0, 11'h000, 6'd0, 1'b0, 1'b0, 1'b1, 5'd4);
        send(19'h00000, 6'd20, 5'd5);
        expect_beat("v_zero", 1'b0, 11'h000, 6'd0, 1'b1, 1'b0, 1'b0, 5'd5);
        send(19'h7FFFD, 6'd12, 5'd6);
        expect_beat("v_m3", 1'b1, 11'h600, 6'd3, 1'b0, 1'b0, 1'b0, 5'd6);
        send(19'h00001, 6'd10, 5'd7);
        expect_beat("v_e0", 1'b0, 11'h000, 6'd0, 1'b0, 1'b0, 1'b1, 5'd7);
        send(19'h00001, 6'd11, 5'd8);
        expect_beat("v_e1", 1'b0, 11'h400, 6'd1, 1'b0, 1'b0, 1'b0, 5'd8);
        send(19'h40000, 6'd55, 5'd9);
        expect_beat("v_e63", 1'b1, 11'h400, 6'd63, 1'b0, 1'b0, 1'b0, 5'd9);
        send(19'h40000, 6'd56, 5'd10);
        expect_beat("v_e64", 1'b1, 11'h7FF, 6'd63, 1'b0, 1'b1, 1'b0, 5'd10);
`ifdef MAC_NORM_RNE_EN
        send(19'h00C03, 6'd30, 5'd11);
        expect_beat("v_c03", 1'b0, 11'h602, 6'd31, 1'b0, 1'b0, 1'b0, 5'd11);
        send(19'h00FFF, 6'd30, 5'd12);
        expect_beat("v_fff", 1'b0, 11'h400, 6'd32, 1'b0, 1'b0, 1'b0, 5'd12);
        send(19'h3FFFF, 6'd10, 5'd13);
        expect_beat("v_3ffff", 1'b0, 11'h400, 6'd18, 1'b0, 1'b0, 1'b0, 5'd13);
`else
        send(19'h00C03, 6'd30, 5'd11);
        expect_beat("v_c03", 1'b0, 11'h601, 6'd31, 1'b0, 1'b0, 1'b0, 5'd11);
        send(19'h00FFF, 6'd30, 5'd12);
        expect_beat("v_fff", 1'b0, 11'h7FF, 6'd31, 1'b0, 1'b0, 1'b0, 5'd12);
        send(19'h3FFFF, 6'd10, 5'd13);
        expect_beat("v_3ffff", 1'b0, 11'h7FF, 6'd17, 1'b0, 1'b0, 1'b0, 5'd13);
`endif
        @(posedge i_clk);
        #1;
        chk("drain.valid", 32'(o_valid), 32'd0);

        // Backpressure: six beats back to back, downstream stalls cycles 2-5.
        sent    = 0;
        rcv     = 0;
        stalled = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            i_ready   = !(cyc >= 2 && cyc <= 5);
            i_valid   = (sent < 6);
            i_psum    = 19'(32'h400 + 32'(sent));
            i_max_exp = 6'd20;
            i_Q_frac  = 5'(sent);
            @(negedge i_clk);
            acc_in = i_valid && o_ready;
            if (!o_ready) stalled = 1'b1;
            if (o_valid && i_ready) begin
                if (rcv < 6) begin
                    chk("bp.norm", 32'(o_norm_sum), 32'h400 + 32'(rcv));
                    chk("bp.qf",   32'(o_Q_frac), 32'(rcv));
                end
                rcv++;
            end
            @(posedge i_clk);
            #1;
            if (acc_in) sent++;
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        chk("bp.sent",       32'(sent), 32'd6);
        chk("bp.received",   32'(rcv), 32'd6);
        chk("bp.ready_fell", 32'(stalled), 32'd1);

        // Flush while both entries are full.
        i_ready = 1'b0;
        send(19'h00400, 6'd20, 5'd1);
        send(19'h00400, 6'd21, 5'd2);
        chk("fl.full_ready", 32'(o_ready), 32'd0);
        chk("fl.full_valid", 32'(o_valid), 32'd1);
        i_flush = 1'b1;
        @(posedge i_clk);
        #1;
        i_flush = 1'b0;
        chk("fl.valid", 32'(o_valid), 32'd0);
        chk("fl.ready", 32'(o_ready), 32'd1);

        // Flush wins over a concurrent accepted beat.
        send(19'h00400, 6'd22, 5'd3);
        i_flush   = 1'b1;
        i_valid   = 1'b1;
        i_psum    = 19'h00400;
        i_max_exp = 6'd23;
        @(posedge i_clk);
        #1;
        i_flush = 1'b0;
        i_valid = 1'b0;
        chk("flp.valid", 32'(o_valid), 32'd0);
        @(posedge i_clk);
        #1;
        chk("flp.dropped", 32'(o_valid), 32'd0);
        chk("flp.ready",   32'(o_ready), 32'd1);

        // Asynchronous reset with both entries full.
        send(19'h00400, 6'd24, 5'd4);
        send(19'h7FFFF, 6'd25, 5'd5);
        chk("ar.full_ready", 32'(o_ready), 32'd0);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("ar.valid", 32'(o_valid), 32'd0);
        chk("ar.ready", 32'(o_ready), 32'd1);
        chk("ar.sgn",   32'(o_sgn), 32'd0);
        chk("ar.norm",  32'(o_norm_sum), 32'd0);
        chk("ar.exp",   32'(o_exp), 32'd0);
        chk("ar.qf",    32'(o_Q_frac), 32'd0);
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        i_ready = 1'b1;
        @(posedge i_clk);
        #1;
        send(19'h7FFFD, 6'd12, 5'd9);
        expect_beat("ar.first", 1'b1, 11'h600, 6'd3, 1'b0, 1'b0, 1'b0, 5'd9);
        @(posedge i_clk);
        #1;
        chk("ar.drain", 32'(o_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
